// File: rtl/alarm_pkg.sv
// Shared state encoding and time field widths for the alarm sequencing controller.
package alarm_pkg;

  localparam int HR_W  = 5;
  localparam int MIN_W = 6;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZE   = 2'd3
  } state_t;

endpackage

// File: rtl/alarm_ctrl_btn_rise.sv
// Single-register rising-edge detector; the history register resets to RST_VAL
// so a button held through reset does not produce an event.
module btn_rise #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= RST_VAL;
    else     prev <= btn;
  end

  assign rise = btn & ~prev;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm sequencing controller: arms, rings on a minute match, snoozes, stops and times out.
// Optional feature: define ALARM_BEEP_EN for a beeping buzzer instead of a steady tone.
//
//   state    | meaning
//   DISARMED | alarm switch off, everything idle
//   ARMED    | waiting for a tick_min whose time equals the alarm time
//   RINGING  | alarm sounding, counting unattended minutes
//   SNOOZE   | silenced, counting down the snooze minutes
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN       = 5,
  parameter int MAX_SNOOZE       = 3,
  parameter int RING_TIMEOUT_MIN = 10,
  parameter int BEEP_DIV         = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_min,
  input  logic [HR_W-1:0]  cur_hr,
  input  logic [MIN_W-1:0] cur_min,
  input  logic [HR_W-1:0]  alm_hr,
  input  logic [MIN_W-1:0] alm_min,
  input  logic             alarm_en,
  input  logic             btn_snooze,
  input  logic             btn_stop,
  output logic             buzzer,
  output logic             ringing,
  output logic             snoozing,
  output logic [5:0]       snooze_left
);

  localparam logic [5:0] SNZ_LEN  = 6'(SNOOZE_MIN);
  localparam logic [3:0] SNZ_MAX  = 4'(MAX_SNOOZE);
  localparam logic [5:0] RING_MAX = 6'(RING_TIMEOUT_MIN);

  state_t     state;
  logic [5:0] ring_cnt;
  logic [5:0] snooze_cnt;
  logic [3:0] snooze_used;
  logic       snz_ev;
  logic       stop_ev;
  logic       match;

  btn_rise #(.RST_VAL(1'b1)) u_snz (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_snooze),
    .rise (snz_ev)
  );

  btn_rise #(.RST_VAL(1'b1)) u_stop (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_stop),
    .rise (stop_ev)
  );

  assign match = ({cur_hr, cur_min} == {alm_hr, alm_min});

  always_ff @(posedge clk) begin
    if (rst || !alarm_en) begin
      state       <= DISARMED;
      ring_cnt    <= '0;
      snooze_cnt  <= '0;
      snooze_used <= '0;
      ringing     <= 1'b0;
      snoozing    <= 1'b0;
      snooze_left <= '0;
    end else begin
      case (state)
        DISARMED: state <= ARMED;

        ARMED: begin
          if (tick_min && match) begin
            state       <= RINGING;
            ring_cnt    <= '0;
            snooze_used <= '0;
            ringing     <= 1'b1;
          end
        end

        RINGING: begin
          if (stop_ev) begin
            state       <= ARMED;
            ring_cnt    <= '0;
            snooze_used <= '0;
            ringing     <= 1'b0;
          end else if (snz_ev && (snooze_used < SNZ_MAX)) begin
            state       <= SNOOZE;
            snooze_cnt  <= SNZ_LEN;
            snooze_left <= SNZ_LEN;
            snooze_used <= snooze_used + 4'd1;
            ringing     <= 1'b0;
            snoozing    <= 1'b1;
          end else if (tick_min) begin
            if (ring_cnt + 6'd1 >= RING_MAX) begin
              state    <= ARMED;
              ring_cnt <= '0;
              ringing  <= 1'b0;
            end else begin
              ring_cnt <= ring_cnt + 6'd1;
            end
          end
        end

        SNOOZE: begin
          if (stop_ev) begin
            state       <= ARMED;
            snooze_cnt  <= '0;
            snooze_used <= '0;
            snoozing    <= 1'b0;
            snooze_left <= '0;
          end else if (tick_min) begin
            // a count of 1 (or a stray 0) finishes the snooze without wrapping
            if (snooze_cnt <= 6'd1) begin
              state       <= RINGING;
              snooze_cnt  <= '0;
              ring_cnt    <= '0;
              snoozing    <= 1'b0;
              snooze_left <= '0;
              ringing     <= 1'b1;
            end else begin
              snooze_cnt  <= snooze_cnt - 6'd1;
              snooze_left <= snooze_cnt - 6'd1;
            end
          end
        end

        default: state <= DISARMED;
      endcase
    end
  end

`ifdef ALARM_BEEP_EN
  logic [BEEP_DIV-1:0] beep_div;
  logic                tone;

  // divider is held at zero with tone high whenever not ringing, so each
  // RINGING entry starts with the buzzer on
  always_ff @(posedge clk) begin
    if (rst || !ringing) begin
      beep_div <= '0;
      tone     <= 1'b1;
    end else begin
      beep_div <= beep_div + 1'b1;
      if (&beep_div) tone <= ~tone;
    end
  end

  assign buzzer = ringing & tone;
`else
  assign buzzer = ringing;
`endif

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed scoreboard bench for alarm_ctrl (alarm at 07:30, default timing parameters).
module tb_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_min;
  logic [4:0] cur_hr;
  logic [5:0] cur_min;
  logic [4:0] alm_hr;
  logic [5:0] alm_min;
  logic       alarm_en;
  logic       btn_snooze;
  logic       btn_stop;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [5:0] snooze_left;

  always #5 clk = ~clk;

  alarm_ctrl #(
    .SNOOZE_MIN       (5),
    .MAX_SNOOZE       (3),
    .RING_TIMEOUT_MIN (10),
    .BEEP_DIV         (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_min    (tick_min),
    .cur_hr      (cur_hr),
    .cur_min     (cur_min),
    .alm_hr      (alm_hr),
    .alm_min     (alm_min),
    .alarm_en    (alarm_en),
    .btn_snooze  (btn_snooze),
    .btn_stop    (btn_stop),
    .buzzer      (buzzer),
    .ringing     (ringing),
    .snoozing    (snoozing),
    .snooze_left (snooze_left)
  );

  typedef struct {
    logic       r;
    logic       s;
    logic [5:0] sl;
    logic       b;
    bit         chkb;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // drive one cycle of inputs, queue the outputs expected after the edge, then check them
  task automatic step_b(input logic t, input logic m, input logic sn, input logic st,
                        input logic er, input logic es, input logic [5:0] esl,
                        input logic eb, input bit chkb, input string tag);
    exp_t e;
    tick_min   = t;
    cur_hr     = 5'd7;
    cur_min    = m ? 6'd30 : 6'd31;
    btn_snooze = sn;
    btn_stop   = st;
    e.r = er; e.s = es; e.sl = esl; e.b = eb; e.chkb = chkb; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".ringing"},     {5'd0, ringing},  {5'd0, e.r});
    chk({e.tag, ".snoozing"},    {5'd0, snoozing}, {5'd0, e.s});
    chk({e.tag, ".snooze_left"}, snooze_left,      e.sl);
    if (e.chkb) chk({e.tag, ".buzzer"}, {5'd0, buzzer}, {5'd0, e.b});
  endtask

  task automatic step(input logic t, input logic m, input logic sn, input logic st,
                      input logic er, input logic es, input logic [5:0] esl, input string tag);
`ifdef ALARM_BEEP_EN
    step_b(t, m, sn, st, er, es, esl, er, 1'b0, tag);
`else
    step_b(t, m, sn, st, er, es, esl, er, 1'b1, tag);
`endif
  endtask

  // one full snooze from RINGING: edge, four countdown ticks, fifth tick rings again
  task automatic snooze_round(input string tag);
    step(0, 0, 1, 0, 0, 1, 6'd5, {tag, "_enter"});
    for (int i = 1; i <= 4; i++)
      step(1, 0, 0, 0, 0, 1, 6'(5 - i), $sformatf("%s_tick%0d", tag, i));
    step(1, 0, 0, 0, 1, 0, 6'd0, {tag, "_reRing"});
  endtask

  initial begin
    alm_hr     = 5'd7;
    alm_min    = 6'd30;
    alarm_en   = 1'b0;
    rst        = 1'b1;

    step(0, 0, 0, 1, 0, 0, 6'd0, "reset0");
    step(0, 0, 0, 1, 0, 0, 6'd0, "reset1");

    // stop held high through reset release must not count as a stop edge
    rst      = 1'b0;
    alarm_en = 1'b1;
    step(0, 0, 0, 1, 0, 0, 6'd0, "arm");
    step(1, 1, 0, 1, 1, 0, 6'd0, "fire");
    step(0, 0, 0, 1, 1, 0, 6'd0, "heldStopNoEvent");
    step(0, 0, 0, 0, 1, 0, 6'd0, "stopReleased");

    step(0, 0, 1, 0, 0, 1, 6'd5, "snz1_enter");
    step(1, 0, 0, 0, 0, 1, 6'd4, "snz1_tick1");
    step(0, 0, 1, 0, 0, 1, 6'd4, "snz1_edgeIgnored");
    step(1, 0, 0, 0, 0, 1, 6'd3, "snz1_tick2");
    step(1, 0, 0, 0, 0, 1, 6'd2, "snz1_tick3");
    step(1, 0, 0, 0, 0, 1, 6'd1, "snz1_tick4");
    step(1, 0, 0, 0, 1, 0, 6'd0, "snz1_reRing");

    snooze_round("snz2");
    snooze_round("snz3");

    step(0, 0, 0, 0, 1, 0, 6'd0, "snz4_prep");
    step(0, 0, 1, 0, 1, 0, 6'd0, "snz4_ignored");
    step(1, 0, 0, 1, 0, 0, 6'd0, "stopBeatsTick");
    step(0, 0, 0, 0, 0, 0, 6'd0, "armedIdle");

    // unattended ring times out after ten minutes
    step(1, 1, 0, 0, 1, 0, 6'd0, "timeout_fire");
    for (int i = 1; i <= 9; i++)
      step(1, 0, 0, 0, 1, 0, 6'd0, $sformatf("timeout_tick%0d", i));
    step(1, 0, 0, 0, 0, 0, 6'd0, "timeout_tick10");
    step(1, 0, 0, 0, 0, 0, 6'd0, "timeout_noMatch");
    step(0, 1, 0, 0, 0, 0, 6'd0, "matchWithoutTick");
    step(1, 1, 0, 0, 1, 0, 6'd0, "reFire");

    // disable wins over a simultaneous snooze edge
    alarm_en = 1'b0;
    step(0, 0, 1, 0, 0, 0, 6'd0, "disableBeatsSnooze");
    alarm_en = 1'b1;
    step(0, 0, 0, 0, 0, 0, 6'd0, "rearm");
    step(1, 1, 0, 0, 1, 0, 6'd0, "fire2");
    step(0, 0, 1, 0, 0, 1, 6'd5, "snz_beforeReset");

    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0, 6'd0, "resetMidSnooze");
    rst = 1'b0;
    step(0, 0, 0, 0, 0, 0, 6'd0, "afterReset_disarmed");
    step(0, 0, 0, 0, 0, 0, 6'd0, "afterReset_armed");
    step(1, 1, 0, 0, 1, 0, 6'd0, "fire3");
    step(0, 0, 0, 1, 0, 0, 6'd0, "stop3");

`ifdef ALARM_BEEP_EN
    step(0, 0, 0, 0, 0, 0, 6'd0, "beep_prep");
    step_b(1, 1, 0, 0, 1, 0, 6'd0, 1'b1, 1'b1, "beep_k0");
    for (int k = 1; k <= 8; k++)
      step_b(0, 0, 0, 0, 1, 0, 6'd0, ((k / 4) % 2) == 0, 1'b1, $sformatf("beep_k%0d", k));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
